// File: rtl/jt053246_pkg.sv
// Shared types for the 053246 draw-request queue: job entry, scheduler states
// and debug read addresses.
package jt053246_pkg;

    typedef struct packed {
        logic [15:0] code;
        logic [9:0]  attr;
        logic        hflip;
        logic        vflip;
        logic [8:0]  hpos;
        logic [3:0]  ysub;
        logic [11:0] hzoom;
        logic        hzkeep;
    } drq_entry_t;

    localparam int unsigned EntryW = $bits(drq_entry_t);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArm  = 2'd1,
        StWait = 2'd2
    } drq_state_e;

    localparam logic [1:0] DbgStatus = 2'd0;
    localparam logic [1:0] DbgDrop   = 2'd1;
    localparam logic [1:0] DbgOvf    = 2'd2;
    localparam logic [1:0] DbgLaunch = 2'd3;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hff : sum[7:0];
    endfunction

endpackage

// File: rtl/jt053246_drq_fifo.sv
// Circular job buffer with push, pop and a synchronous flush that wins over both.
module jt053246_drq_fifo #(
    parameter int unsigned WIDTH = 54,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rd_ptr_q];

    // A full queue rejects pushes even when a pop frees a slot in the same cycle.
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (cen) begin
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({do_push, do_pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (cen && do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/jt053246_drq.sv
// Draw-request queue between the 053246 object scanner and the tile drawer:
// buffers jobs, launches them with a start/busy handshake, flushes at line start.
module jt053246_drq
    import jt053246_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        hs,
    input  logic        sc_start,
    input  logic [15:0] sc_code,
    input  logic [9:0]  sc_attr,
    input  logic        sc_hflip,
    input  logic        sc_vflip,
    input  logic [8:0]  sc_hpos,
    input  logic [3:0]  sc_ysub,
    input  logic [11:0] sc_hzoom,
    input  logic        sc_hzkeep,
    output logic        sc_busy,
    output logic        dw_start,
    output logic [15:0] dw_code,
    output logic [9:0]  dw_attr,
    output logic        dw_hflip,
    output logic        dw_vflip,
    output logic [8:0]  dw_hpos,
    output logic [3:0]  dw_ysub,
    output logic [11:0] dw_hzoom,
    output logic        dw_hzkeep,
    input  logic        dw_busy,
    output logic        empty,
    input  logic [1:0]  st_addr,
    output logic [7:0]  st_dout
);

    logic        hs_l_q, hs_rise;
    drq_entry_t  wr_entry, rd_entry, dw_q;
    logic [CW-1:0] count;
    logic        full, fifo_empty;
    drq_state_e  state_q, state_d;
    logic        launch;
    logic        dw_start_q;
    logic [7:0]  drop_q, ovf_q, launch_q;

    assign hs_rise = hs & ~hs_l_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      hs_l_q <= 1'b0;
        else if (cen) hs_l_q <= hs;
    end

    assign wr_entry = '{
        code:   sc_code,
        attr:   sc_attr,
        hflip:  sc_hflip,
        vflip:  sc_vflip,
        hpos:   sc_hpos,
        ysub:   sc_ysub,
        hzoom:  sc_hzoom,
        hzkeep: sc_hzkeep
    };

    jt053246_drq_fifo #(
        .WIDTH (EntryW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .cen   (cen),
        .push  (sc_start),
        .pop   (launch),
        .flush (hs_rise),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .count (count),
        .full  (full),
        .empty (fifo_empty)
    );

    assign sc_busy = full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      state_q <= StIdle;
        else if (cen) state_q <= state_d;
    end

    // ARM is an unconditional bubble so the drawer has a cycle to raise dw_busy.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!fifo_empty && !hs_rise) begin
                    launch  = 1'b1;
                    state_d = StArm;
                end
            end
            StArm:   state_d = StWait;
            StWait:  if (!dw_busy) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dw_start_q <= 1'b0;
            dw_q       <= '0;
        end else if (cen) begin
            dw_start_q <= launch;
            if (launch) dw_q <= rd_entry;
        end
    end

    assign dw_start  = dw_start_q;
    assign dw_code   = dw_q.code;
    assign dw_attr   = dw_q.attr;
    assign dw_hflip  = dw_q.hflip;
    assign dw_vflip  = dw_q.vflip;
    assign dw_hpos   = dw_q.hpos;
    assign dw_ysub   = dw_q.ysub;
    assign dw_hzoom  = dw_q.hzoom;
    assign dw_hzkeep = dw_q.hzkeep;

    assign empty = fifo_empty & (state_q == StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q   <= '0;
            ovf_q    <= '0;
            launch_q <= '0;
        end else if (cen) begin
            if (launch)  launch_q <= launch_q + 8'd1;
            if (hs_rise) drop_q   <= sat_add8(drop_q, 8'(count));
            // Pushes landing on a flush are dropped silently, not counted as overflow.
            if (sc_start && full && !hs_rise && ovf_q != 8'hff) ovf_q <= ovf_q + 8'd1;
        end
    end

    always_comb begin
        st_dout = '0;
        case (st_addr)
            DbgStatus: st_dout = {state_q, 1'b0, 5'(count)};
            DbgDrop:   st_dout = drop_q;
            DbgOvf:    st_dout = ovf_q;
            DbgLaunch: st_dout = launch_q;
            default:   st_dout = '0;
        endcase
    end

endmodule

// File: tb/tb_jt053246_drq.sv
// Directed bench for the draw-request queue: launch latency, fill/overflow, wrap,
// line flush, flush with simultaneous push, and asynchronous reset.
module tb_jt053246_drq;

    logic        clk = 1'b0;
    logic        rst, cen, hs;
    logic        sc_start;
    logic [15:0] sc_code;
    logic [9:0]  sc_attr;
    logic        sc_hflip, sc_vflip;
    logic [8:0]  sc_hpos;
    logic [3:0]  sc_ysub;
    logic [11:0] sc_hzoom;
    logic        sc_hzkeep;
    logic        sc_busy;
    logic        dw_start;
    logic [15:0] dw_code;
    logic [9:0]  dw_attr;
    logic        dw_hflip, dw_vflip;
    logic [8:0]  dw_hpos;
    logic [3:0]  dw_ysub;
    logic [11:0] dw_hzoom;
    logic        dw_hzkeep;
    logic        dw_busy;
    logic        empty;
    logic [1:0]  st_addr;
    logic [7:0]  st_dout;

    int          n_vec = 0;
    int          n_err = 0;
    int          exp_launch = 0;
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    jt053246_drq #(
        .DEPTH (4),
        .CW    (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .hs        (hs),
        .sc_start  (sc_start),
        .sc_code   (sc_code),
        .sc_attr   (sc_attr),
        .sc_hflip  (sc_hflip),
        .sc_vflip  (sc_vflip),
        .sc_hpos   (sc_hpos),
        .sc_ysub   (sc_ysub),
        .sc_hzoom  (sc_hzoom),
        .sc_hzkeep (sc_hzkeep),
        .sc_busy   (sc_busy),
        .dw_start  (dw_start),
        .dw_code   (dw_code),
        .dw_attr   (dw_attr),
        .dw_hflip  (dw_hflip),
        .dw_vflip  (dw_vflip),
        .dw_hpos   (dw_hpos),
        .dw_ysub   (dw_ysub),
        .dw_hzoom  (dw_hzoom),
        .dw_hzkeep (dw_hzkeep),
        .dw_busy   (dw_busy),
        .empty     (empty),
        .st_addr   (st_addr),
        .st_dout   (st_dout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic st_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
        st_addr = a;
        #1;
        chk(tag, st_dout, exp);
    endtask

    // Other job fields are derived from the code so field ordering is exercised.
    task automatic push_job(input logic [15:0] code, input logic [8:0] hpos);
        sc_start  = 1'b1;
        sc_code   = code;
        sc_hpos   = hpos;
        sc_attr   = code[9:0] ^ 10'h155;
        sc_hflip  = code[0];
        sc_vflip  = code[1];
        sc_ysub   = code[3:0];
        sc_hzoom  = code[11:0];
        sc_hzkeep = code[2];
        step();
        sc_start  = 1'b0;
    endtask

    // Drawer model: checks launch order/spacing, holds dw_busy for `hold` cycles.
    task automatic run_drawer(input int n, input int hold, input int budget);
        int got, last, bcnt;
        got  = 0;
        last = 0;
        bcnt = 0;
        for (int cyc = 0; cyc < budget && got < n; cyc++) begin
            step();
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) dw_busy = 1'b0;
            end
            if (dw_start) begin
                chk("launch_code", dw_code, exp_q[got]);
                if (got > 0) chk("launch_gap", 32'((cyc - last) >= 3), 1);
                last = cyc;
                got++;
                exp_launch++;
                if (hold > 0) begin
                    dw_busy = 1'b1;
                    bcnt    = hold;
                end
            end
        end
        chk("launch_total", got, n);
        dw_busy = 1'b0;
    endtask

    task automatic no_launch(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (dw_start) seen++;
        end
        chk(tag, seen, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cen = 1'b1; hs = 1'b0; sc_start = 1'b0; sc_code = '0; sc_attr = '0;
        sc_hflip = 1'b0; sc_vflip = 1'b0; sc_hpos = '0; sc_ysub = '0; sc_hzoom = '0;
        sc_hzkeep = 1'b0; dw_busy = 1'b0; st_addr = '0;
        step();
        step();

        // Reset state
        chk("rst_sc_busy", sc_busy, 0);
        chk("rst_dw_start", dw_start, 0);
        chk("rst_dw_code", dw_code, 0);
        chk("rst_empty", empty, 1);
        for (int a = 0; a < 4; a++) st_chk("rst_st", 2'(a), 8'h00);
        rst = 1'b0;
        step();

        // Clock enable low: nothing advances
        cen = 1'b0;
        sc_start = 1'b1;
        step();
        step();
        sc_start = 1'b0;
        cen = 1'b1;
        chk("cen_hold_empty", empty, 1);
        st_chk("cen_hold_status", DbgStatusA(), 8'h00);

        // 1. Single job
        push_job(16'h1234, 9'h040);
        chk("t1_no_start_yet", dw_start, 0);
        step();
        exp_launch++;
        chk("t1_start", dw_start, 1);
        chk("t1_code", dw_code, 16'h1234);
        chk("t1_hpos", dw_hpos, 9'h040);
        chk("t1_attr", dw_attr, 10'h361);
        chk("t1_hzoom", dw_hzoom, 12'h234);
        chk("t1_ysub", dw_ysub, 4'h4);
        chk("t1_flags", {dw_hflip, dw_vflip, dw_hzkeep}, 3'b001);
        chk("t1_empty_busy", empty, 0);
        dw_busy = 1'b1;
        step();
        chk("t1_start_pulse", dw_start, 0);
        repeat (4) step();
        dw_busy = 1'b0;
        chk("t1_not_empty", empty, 0);
        repeat (2) step();
        chk("t1_empty", empty, 1);
        st_chk("t1_launch_cnt", 2'd3, 8'd1);

        // 2. Fill and overflow
        push_job(16'h00aa, 9'h000);
        step();
        exp_launch++;
        chk("t2_blocker", dw_code, 16'h00aa);
        dw_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_job(16'h00b0 + 16'(i), 9'(i));
        chk("t2_full", sc_busy, 1);
        st_chk("t2_status", 2'd0, 8'h84);
        push_job(16'h00bf, 9'h1ff);
        st_chk("t2_ovf", 2'd2, 8'd1);
        st_chk("t2_status_kept", 2'd0, 8'h84);
        exp_q = {16'h00b0, 16'h00b1, 16'h00b2, 16'h00b3};
        dw_busy = 1'b0;
        run_drawer(4, 0, 60);
        repeat (3) step();
        chk("t2_empty", empty, 1);

        // 3. Wrap: 10 streamed jobs, drawer busy 4 cycles each
        exp_q = {};
        for (int i = 0; i < 10; i++) exp_q.push_back(16'(i));
        fork
            begin
                int g;
                for (int i = 0; i < 10; i++) begin
                    g = 0;
                    while (sc_busy && g < 200) begin
                        step();
                        g++;
                    end
                    push_job(16'(i), 9'(i * 8));
                end
            end
            run_drawer(10, 4, 400);
        join
        repeat (4) step();
        chk("t3_empty", empty, 1);
        st_chk("t3_launch_cnt", 2'd3, 8'(exp_launch));

        // 4. Flush with one job in flight and three queued
        push_job(16'h00c0, 9'h010);
        step();
        exp_launch++;
        dw_busy = 1'b1;
        for (int i = 1; i < 4; i++) push_job(16'h00c0 + 16'(i), 9'(i));
        st_chk("t4_pre_status", 2'd0, 8'h83);
        hs = 1'b1;
        step();
        st_chk("t4_status", 2'd0, 8'h80);
        st_chk("t4_drop", 2'd1, 8'd3);
        chk("t4_inflight_code", dw_code, 16'h00c0);
        dw_busy = 1'b0;
        no_launch("t4_no_launch", 8);
        chk("t4_empty", empty, 1);
        st_chk("t4_launch_cnt", 2'd3, 8'(exp_launch));

        // 5. Flush while full, with a push in the same cycle
        hs = 1'b0;
        step();
        push_job(16'h00c8, 9'h020);
        step();
        exp_launch++;
        dw_busy = 1'b1;
        for (int i = 1; i < 5; i++) push_job(16'h00c8 + 16'(i), 9'(i));
        chk("t5_full", sc_busy, 1);
        hs = 1'b1;
        push_job(16'h00ee, 9'h0ee);
        st_chk("t5_ovf", 2'd2, 8'd1);
        st_chk("t5_drop", 2'd1, 8'd7);
        st_chk("t5_status", 2'd0, 8'h80);
        dw_busy = 1'b0;
        no_launch("t5_no_launch", 6);
        // Same again into an empty queue
        hs = 1'b0;
        step();
        hs = 1'b1;
        push_job(16'h00ef, 9'h0ef);
        st_chk("t5b_status", 2'd0, 8'h00);
        no_launch("t5b_no_launch", 5);
        st_chk("t5b_drop", 2'd1, 8'd7);
        st_chk("t5b_ovf", 2'd2, 8'd1);

        // 6. Asynchronous reset in WAIT with two jobs queued
        hs = 1'b0;
        step();
        push_job(16'h00f0, 9'h030);
        step();
        dw_busy = 1'b1;
        push_job(16'h00f1, 9'h031);
        push_job(16'h00f2, 9'h032);
        st_chk("t6_pre_status", 2'd0, 8'h82);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_dw_start", dw_start, 0);
        chk("t6_dw_code", dw_code, 0);
        chk("t6_dw_hpos", dw_hpos, 0);
        chk("t6_empty", empty, 1);
        chk("t6_sc_busy", sc_busy, 0);
        for (int a = 0; a < 4; a++) st_chk("t6_st", 2'(a), 8'h00);
        dw_busy = 1'b0;
        step();
        rst = 1'b0;
        step();
        push_job(16'h5a5a, 9'h1ff);
        step();
        chk("t6_relaunch", dw_start, 1);
        chk("t6_relaunch_code", dw_code, 16'h5a5a);
        chk("t6_relaunch_hpos", dw_hpos, 9'h1ff);
        st_chk("t6_launch_cnt", 2'd3, 8'd1);
        // Reset while dw_start is high clears it before the next edge
        rst = 1'b1;
        #1;
        chk("t6_arm_rst_start", dw_start, 0);
        step();
        rst = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    function automatic logic [1:0] DbgStatusA();
        return 2'd0;
    endfunction

endmodule
